// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage valid/ready register chain with bubble collapsing,
// global flush and a registered occupancy counter.
// Optional feature macro: PIPE_CHAIN_SKID_EN adds a one-entry input skid
// register so that pin_ready becomes a pure register output.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   flush                        discard all held beats
//   pin_valid/pin_ready/pin_data upstream handshake and payload
//   pout_valid/pout_ready/pout_data downstream handshake, payload of last stage
//   occupancy                    valid beats held (including skid entry)
//   empty                        occupancy == 0
module pipe_chain #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             pin_valid,
    output logic             pin_ready,
    input  logic [WIDTH-1:0] pin_data,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [WIDTH-1:0] pout_data,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] en;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             accept;
    logic [CNT_W-1:0] occ_d;

    // Load enables ripple from the output side back to stage 0.
    always_comb begin : en_chain
        logic rdy_next;
        rdy_next = pout_ready;
        en       = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            en[i]    = ~valid_q[i] | rdy_next | flush;
            rdy_next = en[i];
        end
    end

`ifdef PIPE_CHAIN_SKID_EN
    logic             skid_valid_q;
    logic             skid_valid_d;
    logic             ready_q;
    logic [WIDTH-1:0] skid_data_q;

    assign pin_ready = ready_q;
    assign accept    = pin_valid & ready_q;

    // Skid entry feeds stage 0 ahead of pin; flush drops it and lets pin through.
    always_comb begin
        src_valid    = accept;
        src_data     = pin_data;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            src_valid = 1'b1;
            src_data  = skid_data_q;
            if (en[0]) begin
                skid_valid_d = 1'b0;
            end
        end else if (accept && !en[0]) begin
            skid_valid_d = 1'b1;
        end
    end

    // ready_q resets low so pin_ready only rises after reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            ready_q      <= ~skid_valid_d;
            if (skid_valid_d && !skid_valid_q) begin
                skid_data_q <= pin_data;
            end
        end
    end
`else
    assign pin_ready = en[0];
    assign accept    = pin_valid & en[0];
    assign src_valid = pin_valid;
    assign src_data  = pin_data;
`endif

    // Stage registers; data only loads when the upstream side holds a beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            if (en[0]) begin
                valid_q[0] <= src_valid;
                if (src_valid) begin
                    data_q[0] <= src_data;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (en[i]) begin
                    valid_q[i] <= valid_q[i-1] & ~flush;
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end
    end

    assign pout_valid = valid_q[DEPTH-1] & ~flush;
    assign pout_data  = data_q[DEPTH-1];
    assign empty      = (occupancy == '0);

    // Occupancy follows handshakes; flush leaves only a beat accepted this cycle.
    always_comb begin
        occ_d = occupancy;
        if (flush) begin
            occ_d = CNT_W'(accept);
        end else begin
            occ_d = occupancy + CNT_W'(accept) - CNT_W'(pout_valid & pout_ready);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed and random traffic for pipe_chain (DEPTH=3),
// checked against a queue model of beats tagged with their acceptance cycle.
module tb_pipe_chain;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = $clog2(DEPTH + 2);
`ifdef PIPE_CHAIN_SKID_EN
    localparam int unsigned CAP  = DEPTH + 1;
    localparam bit          SKID = 1'b1;
`else
    localparam int unsigned CAP  = DEPTH;
    localparam bit          SKID = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             pin_valid = 1'b0;
    logic             pin_ready;
    logic [WIDTH-1:0] pin_data = '0;
    logic             pout_valid;
    logic             pout_ready = 1'b0;
    logic [WIDTH-1:0] pout_data;
    logic [CNT_W-1:0] occupancy;
    logic             empty;

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .pin_valid  (pin_valid),
        .pin_ready  (pin_ready),
        .pin_data   (pin_data),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .pout_data  (pout_data),
        .occupancy  (occupancy),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    // A beat may leave DEPTH cycles after entering the chain; t is that entry cycle.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               t;
    } beat_t;

    beat_t q[$];
    int    cyc = 0;
    bit    armed = 1'b0;
    int    passed = 0;
    int    total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit m_pout_valid();
        return !flush && q.size() > 0 && (cyc - q[0].t >= int'(DEPTH));
    endfunction

    function automatic bit m_pin_ready();
        if (SKID) begin
            return armed && q.size() <= int'(DEPTH);
        end
        return flush || pout_ready || q.size() < int'(DEPTH);
    endfunction

    // One clock cycle: drive, check at the falling edge, then advance the model.
    task automatic cycle(input logic pv, input logic [WIDTH-1:0] pd, input logic pr,
                         input logic fl, output logic acc);
        bit ev, er, pop, skidded;
        pin_valid  = pv;
        pin_data   = pd;
        pout_ready = pr;
        flush      = fl;
        @(negedge clock);
        ev = m_pout_valid();
        er = m_pin_ready();
        chk("pin_ready", 32'(pin_ready), 32'(er));
        chk("pout_valid", 32'(pout_valid), 32'(ev));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        if (ev) begin
            chk("pout_data", 32'(pout_data), 32'(q[0].data));
        end
        acc     = pv & er;
        pop     = ev & pr;
        skidded = SKID && !fl && !pr && q.size() >= int'(DEPTH);
        @(posedge clock);
        #1;
        if (fl) begin
            q.delete();
            if (acc) q.push_back('{pd, cyc});
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{pd, cyc + int'(skidded)});
        end
        cyc++;
        armed = 1'b1;
        pin_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        armed = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        armed = 1'b1;
    endtask

    logic             a;
    logic [WIDTH-1:0] pend;
    bit               have;
    int               k;
    logic [WIDTH-1:0] vals [5];

    initial begin
        // Reset state
        pin_valid = 1'b0;
        flush = 1'b0;
        pout_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_pout_valid", 32'(pout_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_pout_data", 32'(pout_data), 32'd0);
        chk("rst_pin_ready", 32'(pin_ready), SKID ? 32'd0 : 32'd1);
        release_reset();

        // Streaming 1..5 with downstream always ready
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b1, 1'b0, a);
            chk("stream_accept", 32'(a), 32'd1);
            if (i == 4) chk("stream_occ", 32'(occupancy), 32'd3);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);

        // Backpressure: chain absorbs CAP beats, then drains in order
        for (int i = 0; i < 5; i++) vals[i] = WIDTH'(i + 1);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vals[k], 1'b0, 1'b0, a);
            if (a) k++;
        end
        chk("bp_accepted", 32'(k), 32'(CAP));
        chk("bp_occ", 32'(occupancy), 32'(CAP));
        chk("bp_pin_ready", 32'(pin_ready), 32'd0);
        for (int i = 0; i < 12; i++) begin
            cycle(k < 5, (k < 5) ? vals[k] : '0, 1'b1, 1'b0, a);
            if (a) k++;
        end
        chk("bp_all_sent", 32'(k), 32'd5);

        // Bubble collapsing: A, gap, B under backpressure, then release
        cycle(1'b1, 16'h00A0, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, a);
        cycle(1'b1, 16'h00B0, 1'b0, 1'b0, a);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, a);
        chk("bubble_occ", 32'(occupancy), 32'd2);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);

        // Flush with a full chain and a new beat presented in the flush cycle
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hAAAA + 16'(i * 16'h1111), 1'b0, 1'b0, a);
        cycle(1'b1, 16'hCCCC, 1'b1, 1'b1, a);
        chk("flush_accept", 32'(a), SKID ? 32'd0 : 32'd1);
        if (!SKID) chk("flush_occ", 32'(occupancy), 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 2; i++) cycle(1'b1, 16'h5A00 + 16'(i), 1'b0, 1'b0, a);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pout_valid", 32'(pout_valid), 32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        release_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);

        // Random traffic; the upstream source holds a beat until accepted
        have = 1'b0;
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            if (!have) begin
                have = ($urandom_range(0, 99) < 60);
                pend = WIDTH'($urandom);
            end
            cycle(have, pend, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3, a);
            if (a) have = 1'b0;
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);
        chk("final_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised successor to the single-stage valid/ready pipe register.
- DEPTH back-to-back register slices with per-stage bubble collapsing, a global flush, and an occupancy counter.
- Used to retime long datapaths, e.g. cache tag/data paths, without losing throughput under backpressure.
- Optional input skid entry gives a fully registered pin_ready.

Parameters:
- WIDTH, 16, payload width in bits.
- DEPTH, 2, number of register stages; legal range 1..16.
- CNT_W, $clog2(DEPTH+2), width of the occupancy output. This width also covers the optional skid entry.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-high.
- flush  input  1  discards all held beats.
- pin_valid  input  1  upstream beat valid.
- pin_ready  output  1  block accepts the upstream beat this cycle.
- pin_data  input  WIDTH  upstream payload.
- pout_valid  output  1  downstream beat valid.
- pout_ready  input  1  downstream accepts the beat.
- pout_data  output  WIDTH  downstream payload, taken from the last stage.
- occupancy  output  CNT_W  number of valid beats held, including the skid entry when present.
- empty  output  1  occupancy == 0.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valids clear, all stage data registers clear to 0, occupancy = 0, skid entry clear.
  - Outputs while reset is asserted: pout_valid = 0, empty = 1, pout_data = 0.
  - pin_ready is 1 without the skid entry and 0 with it (skid variant detailed below).
  - Reset during traffic: beats in flight are lost; no beat is emitted afterwards.
- Stage i (0 = input side, DEPTH-1 = output side) holds valid_q[i] and data_q[i].
  - Stage i load enable: en[i] = ~valid_q[i] | rdy[i+1] | flush, where rdy[DEPTH] = pout_ready.
  - Stage i upstream valid: v_in[i] = pin_valid for i = 0, else valid_q[i-1].
  - On en[i]: valid_q[i] <= v_in[i] & ~(flush & i>0); data_q[i] <= upstream data.
  - data_q[i] loads only when v_in[i] = 1, which saves power.
- pin_ready = en[0].
  - It is combinational from pout_ready through the chain; there is no registered path unless the option below is enabled.
- pout_valid = valid_q[DEPTH-1] & ~flush.
- Latency: a beat accepted at cycle t appears on pout at cycle t+DEPTH when downstream is ready and the chain is empty.
- Throughput: 1 beat per cycle at steady state. Any bubble is collapsed as soon as the downstream stage is ready.
- Backpressure: with pout_ready = 0, the chain absorbs exactly DEPTH beats, then pin_ready = 0. Held data stays stable while valid and not accepted.
- Flush:
  - All held beats are discarded at the next edge.
  - During the flush cycle, pout_valid = 0 and no handshake completes on pout.
  - pin_ready = 1 during the flush cycle.
  - A pin beat presented in the flush cycle is accepted into stage 0 and survives.
- Occupancy: registered count.
  - Next value = occupancy + (pin_valid & pin_ready) - (pout_valid & pout_ready).
  - On flush, next value = (pin_valid ? 1 : 0).
  - Never exceeds DEPTH, or DEPTH+1 with the skid entry.
- Simultaneous accept and emit on a full chain: occupancy unchanged, and data shifts by one stage.

Optional Feature:
- Macro PIPE_CHAIN_SKID_EN.
- When defined:
  - A one-entry skid register sits in front of stage 0, and pin_ready = ~skid_valid_q, a pure register output.
  - An incoming beat goes directly to stage 0 when en[0] = 1.
  - Otherwise it is captured into the skid entry. The skid entry drains into stage 0 with priority over pin, first in first out.
  - With the skid entry full, pin_ready = 0 in the next cycle.
  - Flush clears the skid entry. A pin beat in the flush cycle goes to stage 0.
  - Capacity is DEPTH+1. Latency is unchanged when the skid entry is empty.
  - During reset, pin_ready = 0; it rises to 1 the cycle after reset deasserts.
- When not defined: no skid logic, and pin_ready is the combinational en[0] described above.

Test Plan:
- DEPTH=3, WIDTH=16, pout_ready=1. Send 0x0001..0x0005 on consecutive cycles -> the same values appear on pout in order, first at cycle t+3. pin_ready stays 1 and occupancy settles at 3.
- DEPTH=3, pout_ready=0. Send 5 beats -> 3 accepted, pin_ready=0 from the cycle after the 3rd accept, occupancy=3. Raise pout_ready -> 0x0001, 0x0002, 0x0003 emitted in order, then beats 4 and 5 follow.
- DEPTH=4. Beats A at t0 and B at t2 (bubble), pout_ready=0 -> A and B pack into stages 3 and 2 with no gap. On release, emitted on consecutive cycles.
- DEPTH=2, chain full (0xAAAA, 0xBBBB). Flush with pin_valid=1, pin_data=0xCCCC -> pout_valid=0 in the flush cycle. Next cycle occupancy=1, and 0xCCCC emerges 2 cycles after acceptance; 0xAAAA and 0xBBBB are never emitted.
- Reset asserted mid-transfer, asynchronous, between clock edges -> pout_valid=0 and occupancy=0 immediately. After release, no stale beat is emitted.
- With PIPE_CHAIN_SKID_EN, DEPTH=2, pout_ready=0. Send 4 beats -> 3 accepted (occupancy=3), pin_ready registered low. Release -> emitted in order 1, 2, 3.
